// File: rtl/input_mem_ctrl_pkg.sv
// rtl/input_mem_ctrl_pkg.sv - shared types and constants for the input_mem sequencer
//
// Purpose: FSM state encoding, staging-buffer depth, the parked write
// addresses used when no beat is arriving, and mod-64 pointer arithmetic.
package input_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEPTH = 64;

  // Out-of-range byte addresses: input_mem drops the write and they can never
  // collide with a read address in the forwarding compare.
  localparam logic [7:0] IDLE_WADDR0 = 8'hFC;
  localparam logic [7:0] IDLE_WADDR1 = 8'hFD;
  localparam logic [7:0] IDLE_WADDR2 = 8'hFE;
  localparam logic [7:0] IDLE_WADDR3 = 8'hFF;

  // 6-bit pointers wrap naturally, giving mod-DEPTH arithmetic.
  function automatic logic [5:0] ptr_add(input logic [5:0] p, input logic [5:0] n);
    return p + n;
  endfunction

endpackage

// File: rtl/input_mem_ctrl.sv
// rtl/input_mem_ctrl.sv - fetch pacing and byte-address sequencer for the 64-byte pixel buffer
//
// Purpose: requests 32-bit read beats while buffer space allows, writes each
// beat at four consecutive byte addresses, and reads the buffer back as a
// circular byte stream, one B/G/R pixel per valid/ready handshake.
// Ports:
//   I_HCLK, I_HRESET_N          clock, synchronous active-low reset
//   I_START, I_NUM_PIXELS       frame start (IDLE only) and pixel count
//   O_FETCH_REQ, I_FETCH_ACK    one-beat read request / address-phase accept
//   I_RVALID                    beat data valid toward input_mem this cycle
//   O_PIXEL_IN_ADDR0..3         byte write addresses to input_mem
//   O_PIXEL_OUT_ADDRB/G/R       byte read addresses to input_mem
//   O_PIX_VALID, I_PIX_READY    pixel handshake with the rotate datapath
//   O_BUSY, O_DONE              frame active / one-cycle frame-end pulse
module input_mem_ctrl
  import input_mem_ctrl_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic        I_HCLK,
  input  logic        I_HRESET_N,
  input  logic        I_START,
  input  logic [15:0] I_NUM_PIXELS,
  output logic        O_FETCH_REQ,
  input  logic        I_FETCH_ACK,
  input  logic        I_RVALID,
  output logic [7:0]  O_PIXEL_IN_ADDR0,
  output logic [7:0]  O_PIXEL_IN_ADDR1,
  output logic [7:0]  O_PIXEL_IN_ADDR2,
  output logic [7:0]  O_PIXEL_IN_ADDR3,
  output logic [7:0]  O_PIXEL_OUT_ADDRB,
  output logic [7:0]  O_PIXEL_OUT_ADDRG,
  output logic [7:0]  O_PIXEL_OUT_ADDRR,
  output logic        O_PIX_VALID,
  input  logic        I_PIX_READY,
  output logic        O_BUSY,
  output logic        O_DONE
);

  localparam logic [2:0] LP_MAX_OUT = 3'(MAX_OUT);

  state_t      r_state;
  logic [5:0]  r_wr_ptr;
  logic [5:0]  r_rd_ptr;
  logic [5:0]  r_hold_ptr;
  logic [6:0]  r_count;
  logic [2:0]  r_outstanding;
  logic [15:0] r_words_req;
  logic [15:0] r_pix_issued;
  logic [15:0] r_pix_acc;
  logic [15:0] r_num_pixels;
  logic        r_pix_valid;
  logic        r_busy;
  logic        r_done;

  logic        w_run;
  logic        w_words_left;
  logic        w_space_ok;
  logic        w_fetch_req;
  logic        w_ack;
  logic        w_wr_en;
  logic        w_accept;
  logic [7:0]  w_avail;
  logic        w_issue;
  logic [5:0]  w_rd_base;
  logic [6:0]  w_count_nxt;
  logic [2:0]  w_out_nxt;
  logic [15:0] w_pix_acc_nxt;
  logic        w_frame_end;

  assign w_run = (r_state == ST_RUN);

  // words_req < (3N+3)>>2 is the same as 4*words_req < 3N for integers.
  assign w_words_left = {r_words_req, 2'b00} < ({2'b00, r_num_pixels} * 18'd3);
  assign w_space_ok   = ({1'b0, r_count} + {3'b000, r_outstanding, 2'b00} + 8'd4) <= 8'(DEPTH);
  assign w_fetch_req  = w_run && w_words_left && (r_outstanding < LP_MAX_OUT) && w_space_ok;
  assign w_ack        = I_FETCH_ACK && w_fetch_req;

  // Beats arriving outside RUN (e.g. in flight across a reset) are dropped.
  assign w_wr_en  = I_RVALID && w_run;
  assign w_accept = r_pix_valid && I_PIX_READY;

  // Bytes written (including this cycle's beat, via forwarding) but not yet issued.
  assign w_avail = {1'b0, r_count} + (w_wr_en ? 8'd4 : 8'd0) - (r_pix_valid ? 8'd3 : 8'd0);
  assign w_issue = w_run && (r_pix_issued < r_num_pixels) && (w_avail >= 8'd3)
                   && (!r_pix_valid || I_PIX_READY);

  assign w_count_nxt   = r_count + (w_wr_en ? 7'd4 : 7'd0) - (w_accept ? 7'd3 : 7'd0);
  assign w_out_nxt     = r_outstanding + {2'b00, w_ack} - {2'b00, w_wr_en};
  assign w_pix_acc_nxt = r_pix_acc + {15'd0, w_accept};
  assign w_frame_end   = (w_pix_acc_nxt == r_num_pixels) && (w_out_nxt == 3'd0);

  assign O_PIXEL_IN_ADDR0 = w_wr_en ? {2'b00, r_wr_ptr}                 : IDLE_WADDR0;
  assign O_PIXEL_IN_ADDR1 = w_wr_en ? {2'b00, ptr_add(r_wr_ptr, 6'd1)}  : IDLE_WADDR1;
  assign O_PIXEL_IN_ADDR2 = w_wr_en ? {2'b00, ptr_add(r_wr_ptr, 6'd2)}  : IDLE_WADDR2;
  assign O_PIXEL_IN_ADDR3 = w_wr_en ? {2'b00, ptr_add(r_wr_ptr, 6'd3)}  : IDLE_WADDR3;

  // Without an issue the presented pixel is re-read so input_mem output stays stable.
  assign w_rd_base         = w_issue ? r_rd_ptr : r_hold_ptr;
  assign O_PIXEL_OUT_ADDRB = {2'b00, w_rd_base};
  assign O_PIXEL_OUT_ADDRG = {2'b00, ptr_add(w_rd_base, 6'd1)};
  assign O_PIXEL_OUT_ADDRR = {2'b00, ptr_add(w_rd_base, 6'd2)};

  assign O_FETCH_REQ = w_fetch_req;
  assign O_PIX_VALID = r_pix_valid;
  assign O_BUSY      = r_busy;
  assign O_DONE      = r_done;

  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_hold_ptr    <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_words_req   <= '0;
      r_pix_issued  <= '0;
      r_pix_acc     <= '0;
      r_num_pixels  <= '0;
      r_pix_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (I_START) begin
            r_num_pixels <= I_NUM_PIXELS;
            r_busy       <= 1'b1;
            if (I_NUM_PIXELS == 16'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_wr_en) r_wr_ptr <= ptr_add(r_wr_ptr, 6'd4);
          if (w_ack)   r_words_req <= r_words_req + 16'd1;
          if (w_issue) begin
            r_hold_ptr   <= r_rd_ptr;
            r_rd_ptr     <= ptr_add(r_rd_ptr, 6'd3);
            r_pix_issued <= r_pix_issued + 16'd1;
          end
          r_count       <= w_count_nxt;
          r_outstanding <= w_out_nxt;
          r_pix_acc     <= w_pix_acc_nxt;
          r_pix_valid   <= w_issue || (r_pix_valid && !I_PIX_READY);
          if (w_frame_end) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          // Next frame always starts at byte 0.
          r_wr_ptr      <= '0;
          r_rd_ptr      <= '0;
          r_hold_ptr    <= '0;
          r_count       <= '0;
          r_outstanding <= '0;
          r_words_req   <= '0;
          r_pix_issued  <= '0;
          r_pix_acc     <= '0;
          r_pix_valid   <= 1'b0;
          r_state       <= ST_IDLE;
          r_busy        <= 1'b0;
          r_done        <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_mem_ctrl.sv
// tb/tb_input_mem_ctrl.sv - self-checking bench for input_mem_ctrl
module tb_input_mem_ctrl;

  logic        clk = 1'b0;
  logic        I_HRESET_N;
  logic        I_START;
  logic [15:0] I_NUM_PIXELS;
  logic        O_FETCH_REQ;
  logic        I_FETCH_ACK;
  logic        I_RVALID;
  logic [7:0]  O_PIXEL_IN_ADDR0, O_PIXEL_IN_ADDR1, O_PIXEL_IN_ADDR2, O_PIXEL_IN_ADDR3;
  logic [7:0]  O_PIXEL_OUT_ADDRB, O_PIXEL_OUT_ADDRG, O_PIXEL_OUT_ADDRR;
  logic        O_PIX_VALID;
  logic        I_PIX_READY;
  logic        O_BUSY;
  logic        O_DONE;

  always #5 clk = ~clk;

  input_mem_ctrl #(.MAX_OUT(4)) dut (
    .I_HCLK(clk), .I_HRESET_N(I_HRESET_N), .I_START(I_START), .I_NUM_PIXELS(I_NUM_PIXELS),
    .O_FETCH_REQ(O_FETCH_REQ), .I_FETCH_ACK(I_FETCH_ACK), .I_RVALID(I_RVALID),
    .O_PIXEL_IN_ADDR0(O_PIXEL_IN_ADDR0), .O_PIXEL_IN_ADDR1(O_PIXEL_IN_ADDR1),
    .O_PIXEL_IN_ADDR2(O_PIXEL_IN_ADDR2), .O_PIXEL_IN_ADDR3(O_PIXEL_IN_ADDR3),
    .O_PIXEL_OUT_ADDRB(O_PIXEL_OUT_ADDRB), .O_PIXEL_OUT_ADDRG(O_PIXEL_OUT_ADDRG),
    .O_PIXEL_OUT_ADDRR(O_PIXEL_OUT_ADDRR), .O_PIX_VALID(O_PIX_VALID),
    .I_PIX_READY(I_PIX_READY), .O_BUSY(O_BUSY), .O_DONE(O_DONE)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Bench-side input_mem: byte array, write-first (forwarding), registered B/G/R.
  logic [7:0] mem [64];
  logic [7:0] rd_b, rd_g, rd_r;

  // Frame-level model: 0 idle, 1 run, 2 done.
  int m_state, m_n, m_beats, m_words, m_pidx;
  int pend[$];
  int g_mode, g_lat, g_start, g_num, g_hold, g_stall_pix, stall_cnt;
  int p_valid, p_acc;
  logic [7:0]  p_ab, p_ag, p_ar;
  logic [23:0] pix_log [64];
  logic [23:0] addr_log [64];
  int first_rv, first_v, last_acc, done_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sval(input int s);
    case (g_mode)
      1:       return 8'(170 + 17 * s);
      2:       return 8'(7 * s + 5);
      default: return 8'(s);
    endcase
  endfunction

  function automatic logic [23:0] trio(input int s);
    logic [7:0] a, b, c;
    a = 8'(s % 64);
    b = 8'((s + 1) % 64);
    c = 8'((s + 2) % 64);
    return {a, b, c};
  endfunction

  function automatic logic [7:0] wa(input int j);
    case (j)
      0:       return O_PIXEL_IN_ADDR0;
      1:       return O_PIXEL_IN_ADDR1;
      2:       return O_PIXEL_IN_ADDR2;
      default: return O_PIXEL_IN_ADDR3;
    endcase
  endfunction

  task automatic check();
    int i;
    logic allowed;
    chk("busy", O_BUSY, m_state != 0);
    chk("done", O_DONE, m_state == 2);
    if (O_DONE && done_c < 0) done_c = cyc;
    for (int j = 0; j < 4; j++)
      chk("wr_addr", wa(j), I_RVALID ? ((4 * m_beats) % 64 + j) : (252 + j));
    if (O_FETCH_REQ) begin
      allowed = (m_state == 1) && (4 * m_words < 3 * m_n) && (pend.size() < 4)
                && ((4 * m_beats - 3 * m_pidx) + 4 * pend.size() + 4 <= 64);
      chk("fetch_allowed", allowed, 1);
    end
    if (O_PIX_VALID) begin
      if (first_v < 0) first_v = cyc;
      chk("pix_in_frame", (m_state == 1) && (m_pidx < m_n), 1);
      if (m_pidx < m_n) begin
        i = m_pidx;
        chk("pix_data", {rd_b, rd_g, rd_r}, {sval(3 * i), sval(3 * i + 1), sval(3 * i + 2)});
        if (!p_valid || p_acc) begin
          chk("pix_addr", {p_ab, p_ag, p_ar}, trio(3 * i));
          if (i < 64) begin
            pix_log[i]  = {rd_b, rd_g, rd_r};
            addr_log[i] = {p_ab, p_ag, p_ar};
          end
        end
        if (!I_PIX_READY)
          chk("hold_addr", {O_PIXEL_OUT_ADDRB, O_PIXEL_OUT_ADDRG, O_PIXEL_OUT_ADDRR}, trio(3 * i));
      end
    end
  endtask

  task automatic update();
    int acc;
    logic [7:0] a;
    if (!I_HRESET_N) begin
      m_state = 0;
      pend.delete();
      p_valid = 0;
      p_acc = 0;
      return;
    end
    acc = O_PIX_VALID && I_PIX_READY;
    if (acc) begin
      m_pidx++;
      last_acc = cyc;
    end
    if (I_RVALID) begin
      for (int j = 0; j < 4; j++) begin
        a = wa(j);
        if (a < 8'd64) mem[a[5:0]] = sval(4 * m_beats + j);
      end
      chk("no_overwrite", (4 * m_beats + 4 - 3 * m_pidx) <= 64, 1);
      if (first_rv < 0) first_rv = cyc;
      m_beats++;
      void'(pend.pop_front());
    end
    rd_b = mem[O_PIXEL_OUT_ADDRB[5:0]];
    rd_g = mem[O_PIXEL_OUT_ADDRG[5:0]];
    rd_r = mem[O_PIXEL_OUT_ADDRR[5:0]];
    if (I_FETCH_ACK) begin
      pend.push_back(cyc + g_lat);
      m_words++;
    end
    p_valid = O_PIX_VALID;
    p_acc = acc;
    p_ab = O_PIXEL_OUT_ADDRB;
    p_ag = O_PIXEL_OUT_ADDRG;
    p_ar = O_PIXEL_OUT_ADDRR;
    case (m_state)
      0: if (I_START) begin
        m_n = int'(I_NUM_PIXELS);
        m_beats = 0; m_words = 0; m_pidx = 0;
        first_rv = -1; first_v = -1; last_acc = -1; done_c = -1;
        m_state = (m_n == 0) ? 2 : 1;
      end
      1: if (m_pidx == m_n && pend.size() == 0) m_state = 2;
      default: m_state = 0;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    I_START      = 1'(g_start);
    I_NUM_PIXELS = 16'(g_num);
    I_FETCH_ACK  = O_FETCH_REQ;
    I_RVALID     = (pend.size() > 0) && (pend[0] <= cyc);
    if (g_hold != 0) I_PIX_READY = 1'b0;
    else if (O_PIX_VALID && m_pidx == g_stall_pix && stall_cnt < 3) begin
      I_PIX_READY = 1'b0;
      stall_cnt++;
    end else I_PIX_READY = 1'b1;
    #1;
    if (I_HRESET_N) check();
    update();
  endtask

  task automatic start_frame(input int n, input int mode, input int lat);
    g_mode = mode; g_lat = lat; g_num = n; g_start = 1;
    step();
    g_start = 0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_state != 0 && k < budget) begin
      step();
      k++;
    end
    chk("frame_complete", m_state, 0);
    chk("pixels_accepted", m_pidx, m_n);
  endtask

  task automatic run_frame(input int n, input int mode, input int lat, input int budget);
    start_frame(n, mode, lat);
    wait_idle(budget);
  endtask

  task automatic check_reset_outputs();
    chk("rst_fetch_req", O_FETCH_REQ, 0);
    chk("rst_pix_valid", O_PIX_VALID, 0);
    chk("rst_busy", O_BUSY, 0);
    chk("rst_done", O_DONE, 0);
    chk("rst_wr_addr", {O_PIXEL_IN_ADDR0, O_PIXEL_IN_ADDR1, O_PIXEL_IN_ADDR2, O_PIXEL_IN_ADDR3}, 32'hFCFDFEFF);
    chk("rst_rd_addr", {O_PIXEL_OUT_ADDRB, O_PIXEL_OUT_ADDRG, O_PIXEL_OUT_ADDRR}, 24'h000102);
  endtask

  initial begin
    int k;
    for (int j = 0; j < 64; j++) mem[j] = 8'h00;
    m_state = 0; m_n = 0; m_beats = 0; m_words = 0; m_pidx = 0;
    g_mode = 0; g_lat = 1; g_start = 0; g_num = 0; g_hold = 0; g_stall_pix = -1; stall_cnt = 0;
    p_valid = 0; p_acc = 0;
    first_rv = -1; first_v = -1; last_acc = -1; done_c = -1;
    I_HRESET_N = 1'b0; I_START = 1'b0; I_NUM_PIXELS = '0;
    I_FETCH_ACK = 1'b0; I_RVALID = 1'b0; I_PIX_READY = 1'b0;
    repeat (3) step();
    I_HRESET_N = 1'b1;
    step();
    check_reset_outputs();

    // Basic frame: four pixels back to back.
    run_frame(4, 0, 1, 100);
    chk("t1_pix0", pix_log[0], 24'h000102);
    chk("t1_pix3", pix_log[3], 24'h090A0B);
    chk("t1_latency", first_v, first_rv + 1);
    chk("t1_throughput", last_acc, first_v + 3);
    chk("t1_done_after", done_c, last_acc + 1);

    // Backpressure on pixel 1 for three cycles.
    stall_cnt = 0; g_stall_pix = 1;
    run_frame(4, 0, 1, 100);
    g_stall_pix = -1;
    chk("t2_stalls", stall_cnt, 3);
    chk("t2_pix1", pix_log[1], 24'h030405);
    chk("t2_last_acc", last_acc, first_v + 6);

    // Full buffer: hold READY low so nothing is freed.
    g_hold = 1;
    start_frame(40, 0, 1);
    repeat (40) step();
    chk("t3_words_when_full", m_words, 16);
    chk("t3_req_dropped", O_FETCH_REQ, 0);
    chk("t3_first_pixel_held", O_PIX_VALID, 1);
    g_hold = 0;
    wait_idle(400);
    chk("t3_words_total", m_words, 30);

    // Wrap of the circular read stream.
    run_frame(30, 0, 2, 400);
    chk("t4_pix21_data", pix_log[21], 24'h3F4041);
    chk("t4_pix21_addr", addr_log[21], 24'h3F0001);

    // Single pixel; padding byte dropped; next frame restarts at 0.
    run_frame(1, 1, 1, 50);
    chk("t5_pix0", pix_log[0], 24'hAABBCC);
    chk("t5_beats", m_beats, 1);
    run_frame(4, 0, 1, 100);
    chk("t5_restart_addr", addr_log[0], 24'h000102);
    chk("t5_restart_pix3", pix_log[3], 24'h090A0B);

    // Empty frame goes straight to DONE.
    start_frame(0, 0, 1);
    wait_idle(10);
    chk("t6_done_seen", done_c >= 0, 1);

    // Reset mid-frame with a beat outstanding.
    start_frame(30, 2, 2);
    k = 0;
    while (!(m_pidx >= 5 && pend.size() > 0) && k < 200) begin
      step();
      k++;
    end
    chk("t7_reached_midframe", (m_pidx >= 5) && (pend.size() > 0), 1);
    I_HRESET_N = 1'b0;
    step();
    I_HRESET_N = 1'b1;
    step();
    check_reset_outputs();
    run_frame(6, 0, 1, 100);
    chk("t7_fresh_pix5", pix_log[5], 24'h0F1011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
